// File: rtl/merge_rr_fflop.sv
// Two-input round-robin merge for Valid/Retry streams with a 2-entry tagged output buffer.
// Input Retry depends only on registered state and the other input's Valid; outRetry only affects pops.
module merge_rr_fflop #(
    parameter int Size = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [Size-1:0] inp_a,
    input  logic            inp_aValid,
    output logic            inp_aRetry,
    input  logic [Size-1:0] inp_b,
    input  logic            inp_bValid,
    output logic            inp_bRetry,
    output logic [Size-1:0] out,
    output logic            out_src,
    output logic            outValid,
    input  logic            outRetry
);

    logic [1:0]    cnt_q, cnt_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          prio_q, prio_d;
    logic [Size:0] buf_q [2];
    logic [Size:0] buf_d [2];

    logic          full;
    logic          grant_a;
    logic          grant_b;
    logic          push;
    logic          pop;
    logic [Size:0] push_word;
    logic [Size:0] head;

    // Arbitration: the loser of the previous grant wins the next tie.
    always_comb begin
        full       = (cnt_q == 2'd2);
        inp_aRetry = full | (inp_bValid & prio_q);
        inp_bRetry = full | (inp_aValid & ~prio_q);
        grant_a    = inp_aValid & ~inp_aRetry;
        grant_b    = inp_bValid & ~inp_bRetry;
        push       = grant_a | grant_b;
        push_word  = grant_a ? {1'b0, inp_a} : {1'b1, inp_b};
    end

    always_comb begin
        head     = buf_q[rd_ptr_q];
        out      = head[Size-1:0];
        out_src  = head[Size];
        outValid = (cnt_q != 2'd0);
        pop      = outValid & ~outRetry;
    end

    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        prio_d   = prio_q;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            buf_d[wr_ptr_q] = push_word;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (grant_a) begin
            prio_d = 1'b1;
        end else if (grant_b) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            prio_q   <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            prio_q   <= prio_d;
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
        end
    end

endmodule
